sram_port_client: RTL and testbench
===================================

Name: sram_port_client

Overview:
- Requester-side endpoint of the SRAM arbiter's request/hint handshake; one instance per arbiter port (slave side or master side).
- Packs an incoming byte stream into 16-bit words and issues write requests.
- Issues read requests and unpacks the returned words into an outgoing byte stream.
- Holds each request level until the arbiter's one-cycle hint pulse and guarantees one outstanding operation at a time.

Parameters:
- PAD_BYTE, 8'h00, high byte used when a flush commits an odd trailing byte.
- TIMEOUT_CYC, 64, cycles to wait for hint before abort (used only with the optional feature).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_byte  in  8  byte to store.
- wr_valid  in  1  wr_byte valid.
- wr_ready  out  1  byte accepted when wr_valid & wr_ready.
- wr_flush  in  1  single-cycle pulse: commit a pending odd byte padded with PAD_BYTE.
- rd_byte  out  8  byte fetched from SRAM.
- rd_valid  out  1  rd_byte valid.
- rd_ready  in  1  consumer accepts rd_byte.
- rd_en  in  1  permit read prefetch.
- req_write  out  1  level write request to arbiter.
- req_read  out  1  level read request to arbiter.
- data_to_sram  out  16  word to write; stable while req_write=1.
- data_from_sram  in  16  read word, valid in the hint cycle.
- hint  in  1  arbiter completion pulse, one cycle, registered by arbiter.
- fifo_full  in  1  target FIFO full (arbiter ignores writes while 1).
- fifo_empty  in  1  source FIFO empty (arbiter ignores reads while 1).
- busy  out  1  request outstanding.
- err_timeout  out  1  sticky hint-timeout flag.

Behaviour:
- Reset (async, rst_n=0):
  - req_write=0, req_read=0, busy=0, wr_ready=0, rd_valid=0, rd_byte=0, data_to_sram=0, err_timeout=0.
  - Partial byte, word buffers and state are cleared.
  - A reset mid-request drops the request immediately; the arbiter's eventual hint is ignored because the FSM is in IDLE.
- Write packer:
  - First accepted byte goes to data_to_sram[7:0], second to [15:8]; the word is then marked pending.
  - wr_ready=1 only while no word is pending and the FSM is not in WR_REQ.
  - wr_flush with exactly one byte held: the high byte is set to PAD_BYTE and the word is marked pending.
  - wr_flush with zero bytes held has no effect.
  - wr_flush in the same cycle as the completing second byte: the real byte wins and no pad is added.
- Read unpacker:
  - A one-word buffer emits the low byte first, then the high byte.
  - rd_valid stays asserted until rd_ready; the buffer is empty after the high byte is accepted.
- FSM states: IDLE, WR_REQ, RD_REQ.
  - IDLE -> WR_REQ when a word is pending and fifo_full=0. Write has priority.
  - Otherwise IDLE -> RD_REQ when rd_en=1, the read buffer is empty and fifo_empty=0.
  - On entry the matching req_* is registered high. Never both high.
  - WR_REQ: on the edge sampling hint=1, req_write<=0, pending cleared, -> IDLE.
  - RD_REQ: on the edge sampling hint=1, data_from_sram is captured into the read buffer, req_read<=0, -> IDLE. rd_valid rises the next cycle.
  - The request is low for at least one cycle between operations; back-to-back operations therefore have a minimum spacing of hint+2 cycles.
  - The full/empty flags are checked only when leaving IDLE. A request already raised is held regardless of later flag changes.
  - hint sampled while in IDLE is ignored.
- busy = (state != IDLE).

Optional Feature:
- Macro: SRAM_CLIENT_HINT_TIMEOUT_EN.
- Defined:
  - A counter runs in WR_REQ/RD_REQ.
  - After TIMEOUT_CYC cycles with no hint: req_* is dropped, err_timeout is set, state -> IDLE.
  - A pending write word is retained and retried; a read returns no data.
  - err_timeout clears only on reset.
- Undefined: no counter; waits indefinitely for hint; err_timeout is tied to 0.

Decomposition:
- Package sram_client_pkg: FSM state encoding, BYTE_W=8, WORD_W=16, default timeout constant.
- Natural sub-module: byte_word_packer, covering the write-side byte pairing and flush padding. The unpacker is small enough to stay inline.

Test Plan:
- Write 8'hA5 then 8'h3C, fifo_full=0, hint two cycles after req_write -> data_to_sram=16'h3CA5, req_write high until the hint edge, then low; wr_ready returns to 1.
- fifo_empty=0, rd_en=1, hint with data_from_sram=16'hBEEF -> rd_byte 8'hEF then 8'hBE, one per rd_ready handshake.
- Pending write word and read eligibility in the same cycle -> req_write asserts first; req_read asserts only after a one-cycle low gap following the write hint.
- Single byte 8'h11 then wr_flush, PAD_BYTE=8'h00 -> data_to_sram=16'h0011 written. wr_flush with no bytes held -> no request.
- fifo_full=1 with a pending word -> req_write stays 0. Deassert fifo_full -> req_write rises the next cycle.
- With SRAM_CLIENT_HINT_TIMEOUT_EN and TIMEOUT_CYC=64, no hint -> req_write drops after 64 cycles, err_timeout=1, word retried. Separately, assert rst_n=0 mid-request -> all outputs 0 immediately.

Source files
------------

// File: rtl/sram_client_pkg.sv
// Shared types and widths for the SRAM arbiter port client.
package sram_client_pkg;
  localparam int BYTE_W      = 8;
  localparam int WORD_W      = 16;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WR_REQ = 2'd1,
    RD_REQ = 2'd2
  } state_e;
endpackage

// File: rtl/sram_port_client_packer.sv
// Write-side byte pairing: low byte first, then high byte; flush pads an odd byte.
module byte_word_packer
  import sram_client_pkg::*;
#(
  parameter logic [BYTE_W-1:0] PAD_BYTE = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] byte_i,
  input  logic              valid_i,
  input  logic              flush_i,
  input  logic              hold_i,
  input  logic              clear_i,
  output logic              ready_o,
  output logic [WORD_W-1:0] word_o,
  output logic              pending_o
);
  logic              held_q, held_d;
  logic              pend_q, pend_d;
  logic              rdy_q;
  logic [WORD_W-1:0] word_q, word_d;
  logic              acc;

  assign acc = valid_i & rdy_q;

  // A completing real byte takes precedence over a same-cycle flush.
  always_comb begin
    held_d = held_q;
    pend_d = pend_q;
    word_d = word_q;
    if (acc) begin
      if (!held_q) begin
        word_d[BYTE_W-1:0] = byte_i;
        held_d             = 1'b1;
      end else begin
        word_d[WORD_W-1:BYTE_W] = byte_i;
        held_d                  = 1'b0;
        pend_d                  = 1'b1;
      end
    end else if (flush_i && held_q) begin
      word_d[WORD_W-1:BYTE_W] = PAD_BYTE;
      held_d                  = 1'b0;
      pend_d                  = 1'b1;
    end
    if (clear_i) pend_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_q <= 1'b0;
      pend_q <= 1'b0;
      rdy_q  <= 1'b0;
      word_q <= '0;
    end else begin
      held_q <= held_d;
      pend_q <= pend_d;
      rdy_q  <= !pend_d && !hold_i;
      word_q <= word_d;
    end
  end

  assign ready_o   = rdy_q;
  assign word_o    = word_q;
  assign pending_o = pend_q;
endmodule

// File: rtl/sram_port_client.sv
// Requester endpoint for the SRAM arbiter: byte-stream writes, prefetching reads.
// Optional hint watchdog: define SRAM_CLIENT_HINT_TIMEOUT_EN.
module sram_port_client
  import sram_client_pkg::*;
#(
  parameter logic [BYTE_W-1:0] PAD_BYTE    = 8'h00,
  parameter int                TIMEOUT_CYC = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] wr_byte,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic              wr_flush,
  output logic [BYTE_W-1:0] rd_byte,
  output logic              rd_valid,
  input  logic              rd_ready,
  input  logic              rd_en,
  output logic              req_write,
  output logic              req_read,
  output logic [WORD_W-1:0] data_to_sram,
  input  logic [WORD_W-1:0] data_from_sram,
  input  logic              hint,
  input  logic              fifo_full,
  input  logic              fifo_empty,
  output logic              busy,
  output logic              err_timeout
);
  state_e            state_q, state_d;
  logic              wr_pend, wr_done, rd_done, to_hit, ack;
  logic [WORD_W-1:0] rbuf_q, rbuf_d;
  logic              rfull_q, rfull_d, rhi_q, rhi_d;

  assign ack = hint;

  byte_word_packer #(.PAD_BYTE(PAD_BYTE)) u_pack (
    .clk      (clk),
    .rst_n    (rst_n),
    .byte_i   (wr_byte),
    .valid_i  (wr_valid),
    .flush_i  (wr_flush),
    .hold_i   (state_d == WR_REQ),
    .clear_i  (wr_done),
    .ready_o  (wr_ready),
    .word_o   (data_to_sram),
    .pending_o(wr_pend)
  );

  // Flags are only consulted in IDLE; once raised, a request waits for hint.
  always_comb begin
    state_d = state_q;
    wr_done = 1'b0;
    rd_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_pend && !fifo_full)                  state_d = WR_REQ;
        else if (rd_en && !rfull_q && !fifo_empty)  state_d = RD_REQ;
      end
      WR_REQ: begin
        if (ack) begin
          state_d = IDLE;
          wr_done = 1'b1;
        end else if (to_hit) state_d = IDLE;
      end
      RD_REQ: begin
        if (ack) begin
          state_d = IDLE;
          rd_done = 1'b1;
        end else if (to_hit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rbuf_d  = rbuf_q;
    rfull_d = rfull_q;
    rhi_d   = rhi_q;
    if (rd_done) begin
      rbuf_d  = data_from_sram;
      rfull_d = 1'b1;
      rhi_d   = 1'b0;
    end else if (rfull_q && rd_ready) begin
      rhi_d   = !rhi_q;
      rfull_d = !rhi_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rbuf_q  <= '0;
      rfull_q <= 1'b0;
      rhi_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rbuf_q  <= rbuf_d;
      rfull_q <= rfull_d;
      rhi_q   <= rhi_d;
    end
  end

`ifdef SRAM_CLIENT_HINT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] to_cnt_q;
  logic             err_q;

  assign to_hit = (to_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // Counter restarts on every request; a timed-out write keeps its word for retry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= (state_q != IDLE && state_d == state_q) ? to_cnt_q + 1'b1 : '0;
      if (state_q != IDLE && !ack && to_hit) err_q <= 1'b1;
    end
  end
  assign err_timeout = err_q;
`else
  assign to_hit      = 1'b0;
  assign err_timeout = 1'b0;
`endif

  assign req_write = (state_q == WR_REQ);
  assign req_read  = (state_q == RD_REQ);
  assign busy      = (state_q != IDLE);
  assign rd_valid  = rfull_q;
  assign rd_byte   = rhi_q ? rbuf_q[WORD_W-1:BYTE_W] : rbuf_q[BYTE_W-1:0];
endmodule

// File: tb/tb_sram_port_client.sv
// Randomized bench for sram_port_client against a queue-based model and arbiter stub.
module tb_sram_port_client;
  localparam logic [7:0] PAD = 8'h00;
  localparam int         TO  = 64;

  logic        clk, rst_n;
  logic [7:0]  wr_byte;
  logic        wr_valid, wr_ready, wr_flush;
  logic [7:0]  rd_byte;
  logic        rd_valid, rd_ready, rd_en;
  logic        req_write, req_read;
  logic [15:0] data_to_sram, data_from_sram;
  logic        hnt, fifo_full, fifo_empty, busy, err_timeout;

  sram_port_client #(.PAD_BYTE(PAD), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .wr_byte(wr_byte), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_flush(wr_flush), .rd_byte(rd_byte),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_en(rd_en),
    .req_write(req_write), .req_read(req_read), .data_to_sram(data_to_sram),
    .data_from_sram(data_from_sram), .hint(hnt), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .busy(busy), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0, n_bad = 0;

  // stimulus requests
  logic        s_wr_valid, s_wr_flush, s_rd_ready, s_rd_en, s_full, s_empty, s_rd_rand;
  logic [7:0]  s_wr_byte;
  logic [15:0] s_rd_word;
  int          s_lat;
  logic        arb_en, chk_hold;
  int          arb_dly;
  // reference model
  logic [15:0] exp_wq[$];
  logic [7:0]  exp_rq[$];
  logic [7:0]  got_log[$];
  logic        m_held, exp_err;
  logic [7:0]  m_lo;
  // expectations carried to the next cycle
  logic        p_valid, p_busy, p_rw, p_rr, p_hint, p_cw, p_cr;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    int sz_w, sz_r;
    logic [15:0] d;
    logic [7:0]  b;
    logic        cur_h;
    @(negedge clk);
    chk("busy", busy, req_write | req_read);
    chk("onehot", req_write & req_read, 0);
    chk("wr_ready", wr_ready, exp_wq.size() == 0);
    chk("rd_valid", rd_valid, exp_rq.size() != 0);
    chk("err_timeout", err_timeout, exp_err);
    if (p_valid) begin
      if (!p_busy) begin
        chk("req_wr_next", req_write, p_cw);
        chk("req_rd_next", req_read, !p_cw && p_cr);
      end else if (p_hint) begin
        chk("gap", req_write | req_read, 0);
      end else if (chk_hold) begin
        chk("hold_wr", req_write, p_rw);
        chk("hold_rd", req_read, p_rr);
      end
    end
    p_busy = busy; p_rw = req_write; p_rr = req_read;
    // arbiter stub: one-cycle completion pulse s_lat cycles after it sees a request
    cur_h = hnt;
    if (cur_h) begin
      hnt = 1'b0;
      arb_dly = -1;
    end else if (arb_en && (req_write || req_read)) begin
      if (arb_dly < 0) arb_dly = s_lat;
      if (arb_dly == 0) begin
        hnt = 1'b1;
        arb_dly = -1;
        if (req_write) begin
          if (exp_wq.size() == 0) chk("wr_unexpected", req_write, 0);
          else chk("wdata", data_to_sram, exp_wq.pop_front());
        end else begin
          d = s_rd_rand ? 16'($urandom) : s_rd_word;
          data_from_sram = d;
          exp_rq.push_back(d[7:0]);
          exp_rq.push_back(d[15:8]);
        end
      end else arb_dly--;
    end
    p_hint = hnt;
    sz_w = exp_wq.size();
    sz_r = exp_rq.size();
    wr_valid = s_wr_valid; wr_byte = s_wr_byte; wr_flush = s_wr_flush;
    if (s_wr_valid && wr_ready) begin
      if (!m_held) begin m_lo = s_wr_byte; m_held = 1'b1; end
      else begin exp_wq.push_back({s_wr_byte, m_lo}); m_held = 1'b0; end
      s_wr_valid = 1'b0;
    end else if (s_wr_flush && m_held) begin
      exp_wq.push_back({PAD, m_lo});
      m_held = 1'b0;
    end
    s_wr_flush = 1'b0;
    rd_ready = s_rd_ready;
    if (s_rd_ready && rd_valid) begin
      if (exp_rq.size() == 0) chk("rd_unexpected", rd_valid, 0);
      else begin
        b = exp_rq.pop_front();
        chk("rd_byte", rd_byte, b);
        got_log.push_back(rd_byte);
      end
    end
    rd_en = s_rd_en; fifo_full = s_full; fifo_empty = s_empty;
    p_cw = (sz_w > 0) && !s_full;
    p_cr = s_rd_en && !s_empty && (sz_r == 0);
    p_valid = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    s_wr_byte = b;
    s_wr_valid = 1'b1;
    while (s_wr_valid && n < 40) begin tick(); n++; end
    if (s_wr_valid) begin
      chk("send_timeout", wr_ready, 1);
      s_wr_valid = 1'b0;
    end
  endtask

  task automatic wait_req_wr(input string tag);
    int n = 0;
    while (!req_write && n < 20) begin tick(); n++; end
    chk({tag, "_req"}, req_write, 1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    s_wr_valid = 1'b0; s_rd_en = 1'b0; s_empty = 1'b1; s_full = 1'b0; s_rd_ready = 1'b1;
    if (m_held) s_wr_flush = 1'b1;
    while ((busy || m_held || exp_wq.size() != 0 || exp_rq.size() != 0) && n < 300) begin
      tick(); n++;
    end
    if (n >= 300) chk({tag, "_drain"}, 16'(busy + m_held + exp_wq.size() + exp_rq.size()), 0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req_wr"}, req_write, 0);
    chk({tag, "_req_rd"}, req_read, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_wr_ready"}, wr_ready, 0);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_rd_byte"}, rd_byte, 0);
    chk({tag, "_data"}, data_to_sram, 0);
    chk({tag, "_err"}, err_timeout, 0);
  endtask

  task automatic model_reset();
    exp_wq.delete(); exp_rq.delete();
    m_held = 1'b0; exp_err = 1'b0; hnt = 1'b0; arb_dly = -1; p_valid = 1'b0;
  endtask

  initial begin
    int n, cnt;
    rst_n = 1'b0; wr_byte = '0; wr_valid = 1'b0; wr_flush = 1'b0; rd_ready = 1'b0;
    rd_en = 1'b0; data_from_sram = '0; hnt = 1'b0; fifo_full = 1'b0; fifo_empty = 1'b1;
    s_wr_valid = 0; s_wr_flush = 0; s_rd_ready = 0; s_rd_en = 0; s_full = 0; s_empty = 1;
    s_rd_rand = 0; s_wr_byte = '0; s_rd_word = '0; s_lat = 2; arb_en = 1; chk_hold = 1;
    m_lo = '0; p_busy = 0; p_rw = 0; p_rr = 0; p_hint = 0; p_cw = 0; p_cr = 0;
    model_reset();
    @(posedge clk); #1;
    chk_reset_outs("rst");
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;

    // A5 then 3C -> one word 16'h3CA5
    send_byte(8'hA5); send_byte(8'h3C);
    wait_req_wr("t1");
    chk("t1_data", data_to_sram, 16'h3CA5);
    drain("t1");
    chk("t1_wr_ready", wr_ready, 1);

    // read BEEF -> EF then BE
    got_log.delete();
    s_rd_word = 16'hBEEF; s_rd_en = 1; s_empty = 0; s_rd_ready = 1;
    n = 0;
    while (got_log.size() < 2 && n < 40) begin tick(); n++; end
    s_rd_en = 0;
    drain("t2");
    chk("t2_nbytes", 16'(got_log.size()), 2);
    if (got_log.size() >= 2) begin
      chk("t2_b0", got_log[0], 8'hEF);
      chk("t2_b1", got_log[1], 8'hBE);
    end

    // fifo_full blocks the write; then write wins over a simultaneous read
    s_full = 1; s_rd_en = 0; s_empty = 1;
    send_byte(8'hA1); send_byte(8'hB2);
    repeat (4) tick();
    chk("t5_hold", req_write, 0);
    s_full = 0; s_rd_en = 1; s_empty = 0; s_rd_word = 16'h5678;
    tick(); tick();
    chk("t3_wr_first", req_write, 1);
    chk("t3_rd_not", req_read, 0);
    n = 0;
    while (!req_read && n < 20) begin tick(); n++; end
    chk("t3_rd_later", req_read, 1);
    s_rd_en = 0;
    drain("t3");

    // odd byte + flush -> padded word; flush with nothing held -> no request
    send_byte(8'h11);
    s_wr_flush = 1;
    wait_req_wr("t4");
    chk("t4_data", data_to_sram, {PAD, 8'h11});
    drain("t4");
    s_wr_flush = 1;
    repeat (5) tick();
    chk("t4_noreq", busy, 0);

    // randomized traffic
    s_rd_rand = 1;
    for (int i = 0; i < 3000; i++) begin
      s_wr_valid = ($urandom % 10) < 6;
      s_wr_byte  = 8'($urandom);
      s_wr_flush = ($urandom % 10) == 0;
      s_rd_ready = $urandom % 2;
      s_rd_en    = ($urandom % 4) != 0;
      s_full     = ($urandom % 4) == 0;
      s_empty    = ($urandom % 4) == 0;
      s_lat      = $urandom % 5;
      tick();
    end
    drain("rand");

`ifdef SRAM_CLIENT_HINT_TIMEOUT_EN
    // no completion pulse: request drops after TO cycles, error sticks, word retried
    arb_en = 0; chk_hold = 0;
    send_byte(8'h77); send_byte(8'h66);
    wait_req_wr("to");
    cnt = 0; n = 0;
    while (req_write && n < 200) begin
      cnt++;
      if (cnt == TO) exp_err = 1'b1;
      tick(); n++;
    end
    chk("to_len", 16'(cnt), 16'(TO));
    chk("to_err", err_timeout, 1);
    chk("to_keep", wr_ready, 0);
    tick();
    chk("to_retry", req_write, 1);
    arb_dly = -1; arb_en = 1; chk_hold = 1; s_lat = 1;
    drain("to");
`else
    cnt = 0;
    chk("no_to_err", err_timeout, 0);
`endif

    // reset in the middle of a write request
    s_lat = 4;
    send_byte(8'h99); send_byte(8'h88);
    wait_req_wr("mid");
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outs("mid_rst");
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    tick();
    p_valid = 1'b0;
    @(negedge clk);
    hnt = 1'b1; data_from_sram = 16'hDEAD;
    tick(); tick();
    chk("idle_hint_busy", busy, 0);
    chk("idle_hint_rdv", rd_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
